// File: rtl/sdp_ram_stream_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : sdp_ram_stream_reader_if
// Brief    : Command, RAM read-port and output-stream signals of the
//            SDP RAM stream reader, grouped as one bundle.
//            master = reader engine side, slave = environment side.
// Revision : 1.0 - initial release
// ============================================================================
interface sdp_ram_stream_reader_if #(
    parameter int DATA = 72,
    parameter int ADDR = 10
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR-1:0]   cmd_base;
    logic [ADDR:0]     cmd_len;
    logic [ADDR-1:0]   ram_rd_addr;
    logic [DATA-1:0]   ram_rd_data;
    logic              m_valid;
    logic              m_ready;
    logic [DATA-1:0]   m_data;
    logic              m_last;
    logic              busy;
    logic              done;

    modport master (
        input  cmd_valid, cmd_base, cmd_len, ram_rd_data, m_ready,
        output cmd_ready, ram_rd_addr, m_valid, m_data, m_last, busy, done
    );

    modport slave (
        output cmd_valid, cmd_base, cmd_len, ram_rd_data, m_ready,
        input  cmd_ready, ram_rd_addr, m_valid, m_data, m_last, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/sdp_ram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : sdp_ram_stream_reader
// Brief    : Accepts a (base, length) command, issues sequential wrapping
//            read addresses to a registered-output RAM and presents the
//            returned words as a valid/ready stream with last marking.
//            A 2-entry output buffer absorbs the one-cycle RAM latency so
//            the stream sustains one word per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module sdp_ram_stream_reader #(
    parameter int DATA = 72,
    parameter int ADDR = 10
) (
    input wire                      clk,
    input wire                      rst_n,
    sdp_ram_stream_reader_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [ADDR:0] c_len_one  = {{ADDR{1'b0}}, 1'b1};
    localparam logic [ADDR:0] c_len_zero = '0;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [ADDR-1:0]   r_base;
    logic [ADDR:0]     r_len;
    logic [ADDR:0]     r_issued;
    logic [ADDR-1:0]   r_addr_hold;
    logic              r_inflight;
    logic              r_inflight_last;

    // Head entry drives the stream directly; the second entry is the skid slot.
    logic              r_m_valid;
    logic              r_m_last;
    logic [DATA-1:0]   r_m_data;
    logic              r_b_valid;
    logic              r_b_last;
    logic [DATA-1:0]   r_b_data;
    logic              r_done;

    logic              w_hs;
    logic              w_pop;
    logic              w_push;
    logic [2:0]        w_occ_next;
    logic              w_room;
    logic              w_issue;
    logic              w_issue_last;
    logic [ADDR-1:0]   w_addr;

    assign w_hs   = bus.cmd_valid && (r_state == S_IDLE);
    assign w_pop  = r_m_valid && bus.m_ready;
    assign w_push = r_inflight;

    // Occupancy once the word issued now lands, assuming no pop next cycle.
    assign w_occ_next = {2'b00, r_m_valid} + {2'b00, r_b_valid}
                      + {2'b00, r_inflight} + 3'd1;
    assign w_room     = w_occ_next <= (3'd2 + {2'b00, w_pop});

    // While in RUN at least one address is still outstanding.
    assign w_issue      = (r_state == S_RUN) && w_room;
    assign w_issue_last = w_issue && ((r_issued + c_len_one) == r_len);
    assign w_addr       = r_base + r_issued[ADDR-1:0];

    // The address must reach the RAM in the issue cycle itself; otherwise
    // the previous address is held so the RAM port stays quiet.
    assign bus.ram_rd_addr = w_issue ? w_addr : r_addr_hold;
    assign bus.cmd_ready   = (r_state == S_IDLE);
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.m_valid     = r_m_valid;
    assign bus.m_data      = r_m_data;
    assign bus.m_last      = r_m_last;
    assign bus.done        = r_done;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_hs && (bus.cmd_len != c_len_zero)) w_state_nxt = S_RUN;
            S_RUN:   if (w_issue_last) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_pop && r_m_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Command capture, issue counter, held address and in-flight tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base          <= '0;
            r_len           <= '0;
            r_issued        <= '0;
            r_addr_hold     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue_last;
            if (w_hs) begin
                r_base   <= bus.cmd_base;
                r_len    <= bus.cmd_len;
                r_issued <= '0;
            end else if (w_issue) begin
                r_issued <= r_issued + c_len_one;
            end
            if (w_issue) begin
                r_addr_hold <= w_addr;
            end
        end
    end

    // Two-entry output buffer: returned words enter the head when it is free
    // (or being popped with the skid slot empty), else the skid slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            r_m_data  <= '0;
            r_b_valid <= 1'b0;
            r_b_last  <= 1'b0;
            r_b_data  <= '0;
        end else if (w_pop) begin
            if (r_b_valid) begin
                r_m_valid <= 1'b1;
                r_m_last  <= r_b_last;
                r_m_data  <= r_b_data;
                r_b_valid <= w_push;
                if (w_push) begin
                    r_b_last <= r_inflight_last;
                    r_b_data <= bus.ram_rd_data;
                end
            end else begin
                r_m_valid <= w_push;
                r_m_last  <= w_push && r_inflight_last;
                if (w_push) begin
                    r_m_data <= bus.ram_rd_data;
                end
            end
        end else if (w_push) begin
            if (!r_m_valid) begin
                r_m_valid <= 1'b1;
                r_m_last  <= r_inflight_last;
                r_m_data  <= bus.ram_rd_data;
            end else begin
                r_b_valid <= 1'b1;
                r_b_last  <= r_inflight_last;
                r_b_data  <= bus.ram_rd_data;
            end
        end
    end

    // Completion pulse: after the last beat leaves, or straight after a
    // zero-length command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done <= 1'b0;
        end else begin
            r_done <= (w_hs && (bus.cmd_len == c_len_zero))
                   || ((r_state == S_DRAIN) && w_pop && r_m_last);
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_push && r_m_valid && r_b_valid && !w_pop));

endmodule
`default_nettype wire

// File: tb/tb_sdp_ram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdp_ram_stream_reader
// Brief    : Self-checking bench for sdp_ram_stream_reader. A table of
//            directed commands plus randomized commands; every beat is
//            compared against a queue of words built from the memory image
//            at command time.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdp_ram_stream_reader;
    localparam int DATA  = 72;
    localparam int ADDR  = 10;
    localparam int DEPTH = 1 << ADDR;

    typedef struct {
        logic [DATA-1:0] data;
        bit              last;
    } beat_t;

    typedef struct {
        logic [ADDR-1:0] base;
        logic [ADDR:0]   len;
        int              mode;       // 0: ready=1, 1: stall pattern, 2: random
        int              exp_beats;
        logic [DATA-1:0] exp_first;
        logic [DATA-1:0] exp_last;
        int              exp_dones;
    } vec_t;

    logic            clk;
    logic            rst_n;
    logic [DATA-1:0] mem [DEPTH];
    logic [DATA-1:0] ram_q;

    int n_tests;
    int n_fail;
    int cyc;
    int beat_cnt;
    int done_cnt;
    int exp_done_cyc;
    int hs_cyc;
    logic [ADDR-1:0] hs_base;
    bit  want_first;
    bit  prev_stall;
    logic [DATA-1:0] prev_data;
    logic prev_last;
    int  cur_beats;
    int  cur_first_cyc;
    int  cur_last_cyc;
    logic [DATA-1:0] cur_first;
    logic [DATA-1:0] cur_lastw;
    beat_t exp_q [$];

    sdp_ram_stream_reader_if #(.DATA(DATA), .ADDR(ADDR)) bus ();

    sdp_ram_stream_reader #(.DATA(DATA), .ADDR(ADDR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read RAM model.
    always @(posedge clk) ram_q <= mem[bus.ram_rd_addr];
    assign bus.ram_rd_data = ram_q;

    task automatic check(input bit ok, input string name,
                         input logic [DATA-1:0] act, input logic [DATA-1:0] exp);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Stream monitor and reference model, sampled away from the active edge.
    always @(negedge clk) begin
        beat_t e;
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            prev_stall   = 1'b0;
            want_first   = 1'b0;
            exp_done_cyc = -100;
        end else begin
            if (prev_stall)
                check(bus.m_valid && bus.m_data == prev_data && bus.m_last == prev_last,
                      "stall_hold", bus.m_data, prev_data);
            if (want_first && cyc == hs_cyc + 1)
                check(bus.ram_rd_addr == hs_base, "first_addr",
                      DATA'(bus.ram_rd_addr), DATA'(hs_base));
            if (want_first && bus.m_valid) begin
                check(cyc - hs_cyc == 3, "first_valid_latency", DATA'(cyc - hs_cyc), DATA'(3));
                want_first = 1'b0;
            end
            if (bus.m_valid && bus.m_ready) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "extra_beat", bus.m_data, '0);
                end else begin
                    e = exp_q.pop_front();
                    check(bus.m_data == e.data, "beat_data", bus.m_data, e.data);
                    check(bus.m_last == e.last, "beat_last", DATA'(bus.m_last), DATA'(e.last));
                end
                if (cur_beats == 0) begin
                    cur_first     = bus.m_data;
                    cur_first_cyc = cyc;
                end
                if (bus.m_last) begin
                    cur_lastw    = bus.m_data;
                    cur_last_cyc = cyc;
                    exp_done_cyc = cyc + 1;
                end
                cur_beats++;
                beat_cnt++;
            end
            if (bus.done || cyc == exp_done_cyc) begin
                check(bus.done && cyc == exp_done_cyc, "done_timing",
                      DATA'(bus.done), DATA'(cyc == exp_done_cyc));
                check(bus.cmd_ready, "ready_with_done", DATA'(bus.cmd_ready), DATA'(1));
                if (bus.done) done_cnt++;
            end
            check(bus.busy == !bus.cmd_ready, "busy_vs_ready",
                  DATA'(bus.busy), DATA'(!bus.cmd_ready));
            if (bus.cmd_valid && bus.cmd_ready) begin
                for (int k = 0; k < int'(bus.cmd_len); k++) begin
                    e.data = mem[(int'(bus.cmd_base) + k) % DEPTH];
                    e.last = (k == int'(bus.cmd_len) - 1);
                    exp_q.push_back(e);
                end
                hs_cyc     = cyc;
                hs_base    = bus.cmd_base;
                want_first = (bus.cmd_len != '0);
                cur_beats  = 0;
                if (bus.cmd_len == '0) exp_done_cyc = cyc + 1;
            end
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_data  = bus.m_data;
            prev_last  = bus.m_last;
        end
    end

    function automatic logic ready_for(input int mode, input int k);
        if (mode == 0) return 1'b1;
        if (mode == 1) begin
            if (k < 3) return 1'b1;
            if (k - 3 < 4) return ((k - 3) % 2) == 0;
            if (k - 3 < 9) return 1'b0;
            return 1'b1;
        end
        return $urandom_range(0, 3) != 0;
    endfunction

    task automatic wait_idle();
        int k = 0;
        while (!bus.cmd_ready && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        check(bus.cmd_ready, "idle_timeout", DATA'(bus.cmd_ready), DATA'(1));
    endtask

    task automatic run_cmd(input logic [ADDR-1:0] base, input logic [ADDR:0] len,
                           input int mode, output int beats, output int dones);
        int b0, d0, k, budget;
        wait_idle();
        b0 = beat_cnt;
        d0 = done_cnt;
        bus.cmd_valid = 1'b1;
        bus.cmd_base  = base;
        bus.cmd_len   = len;
        bus.m_ready   = ready_for(mode, 0);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_base  = ADDR'($urandom);
        bus.cmd_len   = (ADDR+1)'($urandom);
        if (len == '0) check(bus.cmd_ready, "len0_ready", DATA'(bus.cmd_ready), DATA'(1));
        k = 1;
        budget = int'(len) * 12 + 40;
        while (done_cnt == d0 && k < budget) begin
            bus.m_ready = ready_for(mode, k);
            @(posedge clk); #1;
            k++;
        end
        check(done_cnt != d0, "cmd_timeout", DATA'(k), DATA'(budget));
        bus.m_ready = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
        end
        beats = beat_cnt - b0;
        dones = done_cnt - d0;
        check(exp_q.size() == 0, "model_drained", DATA'(exp_q.size()), '0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [8];
        int   beats, dones, k0;
        n_tests = 0; n_fail = 0; cyc = 0; beat_cnt = 0; done_cnt = 0;
        exp_done_cyc = -100; hs_cyc = -100; hs_base = '0;
        want_first = 1'b0; prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
        cur_beats = 0; cur_first = '0; cur_lastw = '0; cur_first_cyc = 0; cur_last_cyc = 0;

        vecs[0] = '{10'd5,    11'd4,    0, 4,    72'd5,    72'd8,    1};
        vecs[1] = '{10'd1022, 11'd4,    0, 4,    72'd1022, 72'd1,    1};
        vecs[2] = '{10'd100,  11'd8,    1, 8,    72'd100,  72'd107,  1};
        vecs[3] = '{10'd300,  11'd0,    0, 0,    72'd0,    72'd0,    1};
        vecs[4] = '{10'd17,   11'd1024, 0, 1024, 72'd17,   72'd16,   1};
        vecs[5] = '{10'd1023, 11'd1,    2, 1,    72'd1023, 72'd1023, 1};
        vecs[6] = '{10'd0,    11'd2,    2, 2,    72'd0,    72'd1,    1};
        vecs[7] = '{10'd500,  11'd12,   2, 12,   72'd500,  72'd511,  1};

        for (int i = 0; i < DEPTH; i++) mem[i] = DATA'(i);
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_base  = '0;
        bus.cmd_len   = '0;
        bus.m_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check(bus.cmd_ready == 1'b1, "rst_cmd_ready", DATA'(bus.cmd_ready), DATA'(1));
        check(bus.m_valid == 1'b0, "rst_m_valid", DATA'(bus.m_valid), '0);
        check(bus.m_last == 1'b0, "rst_m_last", DATA'(bus.m_last), '0);
        check(bus.busy == 1'b0, "rst_busy", DATA'(bus.busy), '0);
        check(bus.done == 1'b0, "rst_done", DATA'(bus.done), '0);
        check(bus.m_data == '0, "rst_m_data", bus.m_data, '0);
        check(bus.ram_rd_addr == '0, "rst_rd_addr", DATA'(bus.ram_rd_addr), '0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table.
        for (int v = 0; v < 8; v++) begin
            run_cmd(vecs[v].base, vecs[v].len, vecs[v].mode, beats, dones);
            check(beats == vecs[v].exp_beats, "vec_beats", DATA'(beats), DATA'(vecs[v].exp_beats));
            check(dones == vecs[v].exp_dones, "vec_dones", DATA'(dones), DATA'(vecs[v].exp_dones));
            if (vecs[v].exp_beats > 0) begin
                check(cur_first == vecs[v].exp_first, "vec_first", cur_first, vecs[v].exp_first);
                check(cur_lastw == vecs[v].exp_last, "vec_last", cur_lastw, vecs[v].exp_last);
                if (vecs[v].mode == 0)
                    check(cur_last_cyc - cur_first_cyc + 1 == vecs[v].exp_beats, "vec_throughput",
                          DATA'(cur_last_cyc - cur_first_cyc + 1), DATA'(vecs[v].exp_beats));
            end
        end

        // Reset in the middle of a 10-word command.
        wait_idle();
        k0 = beat_cnt;
        bus.cmd_valid = 1'b1;
        bus.cmd_base  = 10'd200;
        bus.cmd_len   = 11'd10;
        bus.m_ready   = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        for (int k = 0; k < 50 && beat_cnt - k0 < 3; k++) begin
            @(posedge clk); #1;
        end
        check(beat_cnt - k0 >= 3, "abort_reach_word3", DATA'(beat_cnt - k0), DATA'(3));
        rst_n = 1'b0;
        #1;
        check(bus.m_valid == 1'b0 && bus.m_last == 1'b0, "abort_stream_clear",
              DATA'({bus.m_valid, bus.m_last}), '0);
        check(bus.busy == 1'b0 && bus.cmd_ready == 1'b1, "abort_idle",
              DATA'({bus.busy, bus.cmd_ready}), DATA'(1));
        check(bus.m_data == '0, "abort_m_data", bus.m_data, '0);
        check(bus.ram_rd_addr == '0, "abort_rd_addr", DATA'(bus.ram_rd_addr), '0);
        k0 = done_cnt;
        repeat (3) begin
            @(posedge clk); #1;
            check(bus.done == 1'b0, "abort_no_done_in_rst", DATA'(bus.done), '0);
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check(bus.done == 1'b0 && bus.m_valid == 1'b0, "abort_quiet_after_rst",
                  DATA'({bus.done, bus.m_valid}), '0);
        end
        check(done_cnt == k0, "abort_no_done", DATA'(done_cnt), DATA'(k0));
        run_cmd(10'd400, 11'd5, 0, beats, dones);
        check(beats == 5 && dones == 1, "after_abort_cmd", DATA'(beats), DATA'(5));
        check(cur_first == 72'd400, "after_abort_first", cur_first, 72'd400);

        // Randomized commands over a random memory image.
        for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom, $urandom};
        for (int r = 0; r < 24; r++) begin
            logic [ADDR-1:0] rb;
            logic [ADDR:0]   rl;
            rb = (r % 4 == 0) ? ADDR'(DEPTH - $urandom_range(1, 8)) : ADDR'($urandom);
            rl = (ADDR+1)'($urandom_range(0, 40));
            run_cmd(rb, rl, 2, beats, dones);
            check(beats == int'(rl), "rand_beats", DATA'(beats), DATA'(rl));
            check(dones == 1, "rand_dones", DATA'(dones), DATA'(1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
